coax_rx_word_deserializer: RTL and testbench

Receive-path stage directly downstream of `coax_rx_bit_timer`. It takes the bit timer's `sample` strobe and `synchronized` flag, together with the raw `rx` line, and turns the bit stream into framed coax words: sync bit, DATA_BITS data bits (MSB first), then a parity bit. Each word is presented as a one-cycle-valid parallel word with a parity flag. End of message and framing errors are reported to the receive controller above.

---
 rtl/coax_rx_word_deserializer_if.sv | 36 +++
 rtl/coax_rx_word_deserializer.sv | 195 +++++++++++++++++++
 tb/tb_coax_rx_word_deserializer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/coax_rx_word_deserializer_if.sv
// ---------------------------------------------------------------------------
// coax_rx_word_deserializer_if
//   Bundles the bit-level inputs and the word-level outputs of the coax
//   receive word deserializer.
//   master : drives rx/sample/synchronized and observes the word outputs.
//   slave  : the deserializer itself.
//   Signals:
//     rx, sample, synchronized     bit stream, sample strobe, bit-timer lock
//     active                       message in progress
//     data[DATA_BITS-1:0]          last received word
//     data_valid, parity_error     one-cycle word strobe and its parity flag
//     error, error_code[1:0]       one-cycle framing error pulse and its cause
// ---------------------------------------------------------------------------
interface coax_rx_word_deserializer_if #(
  parameter int DATA_BITS = 10
);
  logic                 rx;
  logic                 sample;
  logic                 synchronized;
  logic                 active;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 parity_error;
  logic                 error;
  logic [1:0]           error_code;

  modport master (
    output rx, sample, synchronized,
    input  active, data, data_valid, parity_error, error, error_code
  );

  modport slave (
    input  rx, sample, synchronized,
    output active, data, data_valid, parity_error, error, error_code
  );
endinterface

// File: rtl/coax_rx_word_deserializer.sv
// ---------------------------------------------------------------------------
// coax_rx_word_deserializer
//   Turns the sampled coax bit stream into framed words: a sync bit of 1,
//   DATA_BITS data bits MSB first, then a parity bit. Each received word is
//   presented for one cycle with its parity check result. A sync bit of 0
//   after a word ends the message; a missing first sync bit or loss of bit
//   timer lock is reported as a framing error.
//   Ports:
//     clk      system clock, rising edge
//     reset_n  synchronous active-low reset
//     bus      coax_rx_word_deserializer_if.slave (see interface header)
//   Parameters:
//     DATA_BITS   data bits per word
//     ODD_PARITY  0: data + parity ones must be even, 1: must be odd
// ---------------------------------------------------------------------------
module coax_rx_word_deserializer #(
  parameter int DATA_BITS  = 10,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  coax_rx_word_deserializer_if.slave    bus
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [1:0] ERR_SYNC_LOST   = 2'b01;
  localparam logic [1:0] ERR_NO_START    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_SYNC,
    S_END
  } state_t;

  // True when the ones count over data plus parity bit disagrees with the
  // configured parity sense.
  function automatic logic parity_fail(input logic [DATA_BITS-1:0] word,
                                       input logic                 pbit);
    return ((^word) ^ pbit) != ODD_PARITY;
  endfunction

  state_t               state_q,   state_d;
  logic                 sync_prev_q;
  logic                 armed_q;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic                 active_q,  active_d;
  logic [DATA_BITS-1:0] data_q,    data_d;
  logic                 dv_q,      dv_d;
  logic                 perr_q,    perr_d;
  logic                 err_q,     err_d;
  logic [1:0]           code_q,    code_d;

  logic                 sync_rise;
  logic                 in_message;

  // armed_q stays low for the first cycle out of reset so that a lock flag
  // already high during reset is absorbed into sync_prev_q rather than
  // being seen as a fresh rising edge.
  assign sync_rise  = armed_q && bus.synchronized && !sync_prev_q;

  assign in_message = (state_q == S_START) || (state_q == S_DATA) ||
                      (state_q == S_PARITY) || (state_q == S_SYNC);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    active_d = active_q;
    data_d   = data_q;
    dv_d     = 1'b0;
    perr_d   = perr_q;
    err_d    = 1'b0;
    code_d   = code_q;

    // Loss of lock takes priority over any coincident sample; the partial
    // word is dropped and data_q keeps the last complete word.
    if (in_message && !bus.synchronized) begin
      state_d  = S_IDLE;
      active_d = 1'b0;
      err_d    = 1'b1;
      code_d   = ERR_SYNC_LOST;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          active_d = 1'b0;
          if (sync_rise) begin
            state_d = S_START;
          end
        end

        S_START: begin
          if (bus.sample) begin
            if (bus.rx) begin
              state_d  = S_DATA;
              active_d = 1'b1;
              cnt_d    = '0;
            end else begin
              state_d = S_IDLE;
              err_d   = 1'b1;
              code_d  = ERR_NO_START;
            end
          end
        end

        S_DATA: begin
          if (bus.sample) begin
            shift_d = {shift_q[DATA_BITS-2:0], bus.rx};
            if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
              state_d = S_PARITY;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end

        S_PARITY: begin
          if (bus.sample) begin
            data_d  = shift_q;
            dv_d    = 1'b1;
            perr_d  = parity_fail(shift_q, bus.rx);
            state_d = S_SYNC;
          end
        end

        S_SYNC: begin
          if (bus.sample) begin
            if (bus.rx) begin
              state_d = S_DATA;
              cnt_d   = '0;
            end else begin
              state_d  = S_END;
              active_d = 1'b0;
            end
          end
        end

        S_END: begin
          if (!bus.synchronized) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d  = S_IDLE;
          active_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      sync_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      active_q    <= 1'b0;
      data_q      <= '0;
      dv_q        <= 1'b0;
      perr_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      sync_prev_q <= bus.synchronized;
      armed_q     <= 1'b1;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      data_q      <= data_d;
      dv_q        <= dv_d;
      perr_q      <= perr_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

  // Shift register only holds in-flight bits; it is always rewritten before
  // being loaded into data_q, so it needs no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign bus.active       = active_q;
  assign bus.data         = data_q;
  assign bus.data_valid   = dv_q;
  assign bus.parity_error = perr_q;
  assign bus.error        = err_q;
  assign bus.error_code   = code_q;

endmodule

// File: tb/tb_coax_rx_word_deserializer.sv
module tb_coax_rx_word_deserializer;

  localparam int DB = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx_s = 1'b0;
  logic sample_s = 1'b0;
  logic sync_s = 1'b0;

  always #5 clk = ~clk;

  coax_rx_word_deserializer_if #(.DATA_BITS(DB)) bus0 ();
  coax_rx_word_deserializer_if #(.DATA_BITS(DB)) bus1 ();

  assign bus0.rx = rx_s;
  assign bus0.sample = sample_s;
  assign bus0.synchronized = sync_s;
  assign bus1.rx = rx_s;
  assign bus1.sample = sample_s;
  assign bus1.synchronized = sync_s;

  coax_rx_word_deserializer #(.DATA_BITS(DB), .ODD_PARITY(1'b0)) dut_even (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave));

  coax_rx_word_deserializer #(.DATA_BITS(DB), .ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave));

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [DB-1:0] d;
    logic          pe;
  } word_t;

  word_t q0[$];
  word_t q1[$];
  int    eq0[$];
  int    eq1[$];

  word_t w0, w1;
  int    e0, e1;
  int    scnt = 0;
  int    dv_last = 0;
  int    dv_prev = 0;
  logic  prev_sample = 1'b0;

  // Scoreboard: pop and compare whenever either DUT presents a word or error.
  always @(negedge clk) begin
    if (bus0.data_valid) begin
      chk("dv_latency_even", int'(prev_sample), 1);
      if (q0.size() == 0) chk("dv_unexpected_even", 1, 0);
      else begin
        w0 = q0.pop_front();
        chk("data_even", int'(bus0.data), int'(w0.d));
        chk("perr_even", int'(bus0.parity_error), int'(w0.pe));
      end
      dv_prev = dv_last;
      dv_last = scnt;
    end
    if (bus1.data_valid) begin
      if (q1.size() == 0) chk("dv_unexpected_odd", 1, 0);
      else begin
        w1 = q1.pop_front();
        chk("data_odd", int'(bus1.data), int'(w1.d));
        chk("perr_odd", int'(bus1.parity_error), int'(w1.pe));
      end
    end
    if (bus0.error) begin
      if (eq0.size() == 0) chk("err_unexpected_even", int'(bus0.error_code), 0);
      else begin
        e0 = eq0.pop_front();
        chk("err_code_even", int'(bus0.error_code), e0);
      end
      if (bus0.data_valid) chk("dv_err_excl_even", 1, 0);
    end
    if (bus1.error) begin
      if (eq1.size() == 0) chk("err_unexpected_odd", int'(bus1.error_code), 0);
      else begin
        e1 = eq1.pop_front();
        chk("err_code_odd", int'(bus1.error_code), e1);
      end
      if (bus1.data_valid) chk("dv_err_excl_odd", 1, 0);
    end
    if (sample_s) scnt++;
    prev_sample = sample_s;
  end

  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    rx_s = b;
    sample_s = 1'b1;
    @(posedge clk); #1;
    sample_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DB-1:0] d, input logic p);
    for (int i = DB - 1; i >= 0; i--) send_bit(d[i]);
    send_bit(p);
  endtask

  task automatic expect_word(input logic [DB-1:0] d, input logic pe_even,
                             input logic pe_odd);
    word_t w;
    w.d = d;
    w.pe = pe_even;
    q0.push_back(w);
    w.pe = pe_odd;
    q1.push_back(w);
  endtask

  task automatic expect_err(input int code);
    eq0.push_back(code);
    eq1.push_back(code);
  endtask

  task automatic start_msg();
    sync_s = 1'b0;
    repeat (2) @(posedge clk);
    #1 sync_s = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic end_msg();
    sync_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_active(input string nm, input logic exp);
    chk({nm, "_even"}, int'(bus0.active), int'(exp));
    chk({nm, "_odd"},  int'(bus1.active), int'(exp));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_active"}, int'(bus0.active), 0);
    chk({nm, "_data"},   int'(bus0.data), 0);
    chk({nm, "_dv"},     int'(bus0.data_valid), 0);
    chk({nm, "_perr"},   int'(bus0.parity_error), 0);
    chk({nm, "_err"},    int'(bus0.error), 0);
    chk({nm, "_code"},   int'(bus0.error_code), 0);
    chk({nm, "_data_odd"}, int'(bus1.data), 0);
    chk({nm, "_active_odd"}, int'(bus1.active), 0);
  endtask

  typedef struct {
    logic [DB-1:0] d;
    logic          p;
    logic          pe_even;
    logic          pe_odd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{d: 10'h296, p: 1'b1, pe_even: 1'b0, pe_odd: 1'b1};
    vecs[1] = '{d: 10'h296, p: 1'b0, pe_even: 1'b1, pe_odd: 1'b0};
    vecs[2] = '{d: 10'h000, p: 1'b0, pe_even: 1'b0, pe_odd: 1'b1};
    vecs[3] = '{d: 10'h3FF, p: 1'b0, pe_even: 1'b0, pe_odd: 1'b1};
    vecs[4] = '{d: 10'h001, p: 1'b1, pe_even: 1'b0, pe_odd: 1'b1};
    vecs[5] = '{d: 10'h155, p: 1'b1, pe_even: 1'b0, pe_odd: 1'b1};
    vecs[6] = '{d: 10'h2AA, p: 1'b0, pe_even: 1'b1, pe_odd: 1'b0};
    vecs[7] = '{d: 10'h0FF, p: 1'b1, pe_even: 1'b1, pe_odd: 1'b0};

    // Reset with lock already high: must not start a message afterwards.
    reset_n = 1'b0;
    sync_s = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    chk_active("no_edge_after_reset", 1'b0);
    end_msg();

    // Single-word messages from the table.
    for (int v = 0; v < 8; v++) begin
      start_msg();
      send_bit(1'b1);
      chk_active("active_after_sync", 1'b1);
      expect_word(vecs[v].d, vecs[v].pe_even, vecs[v].pe_odd);
      send_word(vecs[v].d, vecs[v].p);
      chk_active("active_before_end", 1'b1);
      send_bit(1'b0);
      chk_active("active_after_end", 1'b0);
      end_msg();
    end

    // Back-to-back words separated only by a sync bit.
    start_msg();
    send_bit(1'b1);
    expect_word(10'h3FF, 1'b0, 1'b1);
    send_word(10'h3FF, 1'b0);
    send_bit(1'b1);
    expect_word(10'h001, 1'b0, 1'b1);
    send_word(10'h001, 1'b1);
    send_bit(1'b0);
    chk("b2b_sample_gap", dv_last - dv_prev, 12);
    chk_active("b2b_active_after_end", 1'b0);
    end_msg();

    // Missing first sync bit.
    expect_err(2);
    start_msg();
    send_bit(1'b0);
    chk_active("no_start_active", 1'b0);
    chk("no_start_code_held", int'(bus0.error_code), 2);
    end_msg();

    // Loss of lock after 4 data bits, coincident with a sample.
    start_msg();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    expect_err(1);
    @(posedge clk); #1;
    rx_s = 1'b1;
    sample_s = 1'b1;
    sync_s = 1'b0;
    @(posedge clk); #1;
    sample_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("los_data_held", int'(bus0.data), 10'h001);
    chk_active("los_active", 1'b0);
    chk("los_code_held", int'(bus0.error_code), 1);

    // Reset mid-word: silent discard.
    start_msg();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("mid_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    end_msg();

    // After reset and loss of lock the receiver is back in IDLE.
    start_msg();
    send_bit(1'b1);
    expect_word(10'h296, 1'b1, 1'b0);
    send_word(10'h296, 1'b0);
    send_bit(1'b0);
    end_msg();

    chk("word_queue_even_drained", q0.size(), 0);
    chk("word_queue_odd_drained", q1.size(), 0);
    chk("err_queue_even_drained", eq0.size(), 0);
    chk("err_queue_odd_drained", eq1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
